// File: rtl/cdb_arbiter_pkg.sv
// Shared types and widths for the common-data-bus arbiter.
// Result payload layout plus index-width helpers.
package cdb_arbiter_pkg;

    localparam int N_CDB_DEF = 2;
    localparam int ROB_IDX_W = 5;
    localparam int PRF_IDX_W = 6;
    localparam int ARCH_W    = 5;
    localparam int DATA_W    = 32;

    typedef struct packed {
        logic [ROB_IDX_W-1:0] rob_id;
        logic [PRF_IDX_W-1:0] rd_phy;
        logic [ARCH_W-1:0]    rd_arch;
        logic [DATA_W-1:0]    rd_value;
    } cdb_entry_t;

    // Index width that stays legal when only one element exists.
    function automatic int idx_w(input int n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

endpackage

// File: rtl/cdb_arbiter_src_fifo.sv
// Per-source result buffer: small FIFO with flush.
// Ready is a registered-count compare, no same-cycle pop credit.
module cdb_src_fifo
    import cdb_arbiter_pkg::*;
#(
    parameter int DEPTH = 2
) (
    input  logic                       clk_i,
    input  logic                       rst_i,
    input  logic                       flush_i,
    input  logic                       push_i,
    input  logic                       pop_i,
    input  cdb_entry_t                 data_i,
    output cdb_entry_t                 data_o,
    output logic                       ready_o,
    output logic [$clog2(DEPTH+1)-1:0] count_o
);

    localparam int CW = $clog2(DEPTH + 1);
    localparam int PW = idx_w(DEPTH);

    cdb_entry_t    mem_q [DEPTH];
    logic [PW-1:0] wr_ptr_q, wr_ptr_d;
    logic [PW-1:0] rd_ptr_q, rd_ptr_d;
    logic [CW-1:0] count_q, count_d;
    logic          do_push;
    logic          do_pop;

    assign ready_o = (count_q != CW'(DEPTH)) && !rst_i;
    assign do_push = push_i && ready_o;
    assign do_pop  = pop_i && (count_q != '0);
    assign data_o  = mem_q[rd_ptr_q];
    assign count_o = count_q;

    generate
        if (DEPTH == 1) begin : g_ptr_tied
            assign wr_ptr_d = '0;
            assign rd_ptr_d = '0;
        end else begin : g_ptr_wrap
            function automatic logic [PW-1:0] nxt(input logic [PW-1:0] p);
                return (p == PW'(DEPTH - 1)) ? '0 : p + PW'(1);
            endfunction

            always_comb begin
                wr_ptr_d = do_push ? nxt(wr_ptr_q) : wr_ptr_q;
                rd_ptr_d = do_pop  ? nxt(rd_ptr_q) : rd_ptr_q;
            end
        end
    endgenerate

    always_comb begin
        count_d = count_q;
        unique case ({do_push, do_pop})
            2'b10:   count_d = count_q + CW'(1);
            2'b01:   count_d = count_q - CW'(1);
            default: count_d = count_q;
        endcase
    end

    always_ff @(posedge clk_i) begin
        if (rst_i || flush_i) begin
            count_q  <= '0;
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
        end else begin
            count_q  <= count_d;
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
        end
    end

    // Storage needs no reset; the count gates every read.
    always_ff @(posedge clk_i) begin
        if (do_push && !flush_i) begin
            mem_q[wr_ptr_q] <= data_i;
        end
    end

endmodule

// File: rtl/cdb_arbiter.sv
// Round-robin arbiter from N_SRC FU result buffers onto N_CDB
// registered broadcast lanes, packed from lane 0.
module cdb_arbiter
    import cdb_arbiter_pkg::*;
#(
    parameter int N_SRC     = 4,
    parameter int N_CDB     = N_CDB_DEF,
    parameter int BUF_DEPTH = 2
) (
    input  logic                                 clk,
    input  logic                                 rst,
    input  logic                                 flush,
    input  logic       [N_SRC-1:0]               src_valid,
    output logic       [N_SRC-1:0]               src_ready,
    input  cdb_entry_t [N_SRC-1:0]               src_entry,
    output logic       [N_CDB-1:0]               cdb_valid,
    output cdb_entry_t [N_CDB-1:0]               cdb_entry,
    output logic [N_CDB-1:0][idx_w(N_SRC)-1:0]   cdb_src_id
);

    localparam int SRC_W = idx_w(N_SRC);
    localparam int CW    = $clog2(BUF_DEPTH + 1);

    cdb_entry_t [N_SRC-1:0]           head;
    logic       [N_SRC-1:0][CW-1:0]   cnt;
    logic       [N_SRC-1:0]           pop;

    logic       [N_CDB-1:0]             vld_d, vld_q;
    cdb_entry_t [N_CDB-1:0]             ent_d, ent_q;
    logic       [N_CDB-1:0][SRC_W-1:0]  sid_d, sid_q;
    logic       [SRC_W-1:0]             rr_ptr_d, rr_ptr_q;

    generate
        for (genvar g = 0; g < N_SRC; g++) begin : g_src
            cdb_src_fifo #(
                .DEPTH (BUF_DEPTH)
            ) u_fifo (
                .clk_i   (clk),
                .rst_i   (rst),
                .flush_i (flush),
                .push_i  (src_valid[g]),
                .pop_i   (pop[g]),
                .data_i  (src_entry[g]),
                .data_o  (head[g]),
                .ready_o (src_ready[g]),
                .count_o (cnt[g])
            );
        end
    endgenerate

    // Scan from rr_ptr; the k-th non-empty source takes lane k.
    always_comb begin
        int idx;
        int nsel;
        idx      = 0;
        nsel     = 0;
        pop      = '0;
        vld_d    = '0;
        ent_d    = '0;
        sid_d    = '0;
        rr_ptr_d = rr_ptr_q;
        for (int i = 0; i < N_SRC; i++) begin
            idx = int'(rr_ptr_q) + i;
            if (idx >= N_SRC) begin
                idx = idx - N_SRC;
            end
            if ((cnt[idx] != '0) && (nsel < N_CDB)) begin
                pop[idx]    = 1'b1;
                vld_d[nsel] = 1'b1;
                ent_d[nsel] = head[idx];
                sid_d[nsel] = SRC_W'(idx);
                rr_ptr_d    = (idx == N_SRC - 1) ? '0 : SRC_W'(idx + 1);
                nsel        = nsel + 1;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst || flush) begin
            vld_q    <= '0;
            ent_q    <= '0;
            sid_q    <= '0;
            rr_ptr_q <= '0;
        end else begin
            vld_q    <= vld_d;
            ent_q    <= ent_d;
            sid_q    <= sid_d;
            rr_ptr_q <= rr_ptr_d;
        end
    end

    assign cdb_valid  = vld_q;
    assign cdb_entry  = ent_q;
    assign cdb_src_id = sid_q;

endmodule

// File: tb/tb_cdb_arbiter.sv
// Directed and random checks for cdb_arbiter, with a per-source
// scoreboard that also bounds the wait of every result.
module tb_cdb_arbiter;
    import cdb_arbiter_pkg::*;

    localparam int NS     = 4;
    localparam int NC     = 2;
    localparam int BD     = 2;
    localparam int SW     = 2;
    localparam int MAXLAT = ((NS + NC - 1) / NC) * BD;

    typedef struct {
        cdb_entry_t e;
        int         t;
    } sb_t;

    logic                        clk = 1'b0;
    logic                        rst;
    logic                        flush;
    logic       [NS-1:0]         src_valid;
    logic       [NS-1:0]         src_ready;
    cdb_entry_t [NS-1:0]         src_entry;
    logic       [NC-1:0]         cdb_valid;
    cdb_entry_t [NC-1:0]         cdb_entry;
    logic       [NC-1:0][SW-1:0] cdb_src_id;

    sb_t          sbq [NS][$];
    int           total = 0;
    int           bad   = 0;
    int           ecnt  = 0;
    int           seq   = 0;
    int           nbc [NS];
    logic [NS-1:0] acc;
    cdb_entry_t   ex [NS];

    always #5 clk = ~clk;

    cdb_arbiter #(
        .N_SRC     (NS),
        .N_CDB     (NC),
        .BUF_DEPTH (BD)
    ) dut (
        .clk        (clk),
        .rst        (rst),
        .flush      (flush),
        .src_valid  (src_valid),
        .src_ready  (src_ready),
        .src_entry  (src_entry),
        .cdb_valid  (cdb_valid),
        .cdb_entry  (cdb_entry),
        .cdb_src_id (cdb_src_id)
    );

    always @(posedge clk) ecnt <= ecnt + 1;

    task automatic check(input string tag, input logic [63:0] got,
                         input logic [63:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s got=0x%0h exp=0x%0h", tag, got, exp);
        end
    endtask

    function automatic cdb_entry_t mk(input int rob, input int phy,
                                      input int arch, input logic [31:0] v);
        cdb_entry_t e;
        e.rob_id   = ROB_IDX_W'(rob);
        e.rd_phy   = PRF_IDX_W'(phy);
        e.rd_arch  = ARCH_W'(arch);
        e.rd_value = v;
        return e;
    endfunction

    function automatic cdb_entry_t newent(input int s);
        seq++;
        return mk(seq, seq + s, s, {8'(s), 24'(seq)});
    endfunction

    // Record accepted pushes, then advance one clock.
    task automatic tick();
        logic fl;
        sb_t  it;
        #1;
        fl  = rst | flush;
        acc = src_valid & src_ready & {NS{!fl}};
        for (int s = 0; s < NS; s++) begin
            if (acc[s]) begin
                it.e = src_entry[s];
                it.t = ecnt + 1;
                sbq[s].push_back(it);
            end
        end
        @(posedge clk);
        #1;
        if (fl) begin
            for (int s = 0; s < NS; s++) sbq[s].delete();
        end
    endtask

    task automatic clean();
        src_valid = '0;
        flush     = 1'b1;
        tick();
        flush     = 1'b0;
        check("clean_rr", 64'(dut.rr_ptr_q), 0);
        check("clean_vld", 64'(cdb_valid), 0);
    endtask

    always @(negedge clk) begin
        for (int l = 0; l < NC; l++) begin
            if (cdb_valid[l]) begin
                int  s;
                sb_t it;
                s = int'(cdb_src_id[l]);
                nbc[s]++;
                check("sb_pending", 64'(sbq[s].size() > 0), 1);
                if (sbq[s].size() > 0) begin
                    it = sbq[s].pop_front();
                    check("sb_entry", 64'(cdb_entry[l]), 64'(it.e));
                    check("sb_wait",
                          64'((ecnt - it.t) >= 1 && (ecnt - it.t) <= MAXLAT), 1);
                end
            end
        end
    end

    initial begin
        int           na;
        int           base;
        logic [5:0]   rdy_tbl;
        cdb_entry_t   e1;

        for (int s = 0; s < NS; s++) nbc[s] = 0;
        rst       = 1'b1;
        flush     = 1'b0;
        src_valid = '0;
        src_entry = '0;

        for (int i = 0; i < 3; i++) begin
            tick();
            check("rst_ready", 64'(src_ready), 0);
            check("rst_valid", 64'(cdb_valid), 0);
        end
        rst = 1'b0;
        #1;
        check("idle_ready", 64'(src_ready), 64'hF);
        check("idle_ent0", 64'(cdb_entry[0]), 0);
        check("idle_ent1", 64'(cdb_entry[1]), 0);
        check("idle_sid", 64'(cdb_src_id), 0);
        check("idle_rr", 64'(dut.rr_ptr_q), 0);

        e1 = mk(7, 12, 3, 32'hDEADBEEF);
        src_valid    = 4'b0100;
        src_entry[2] = e1;
        tick();
        src_valid = '0;
        check("one_t1_vld", 64'(cdb_valid), 0);
        tick();
        check("one_vld", 64'(cdb_valid), 64'b01);
        check("one_ent", 64'(cdb_entry[0]), 64'(e1));
        check("one_sid", 64'(cdb_src_id[0]), 2);
        tick();
        check("one_pulse", 64'(cdb_valid), 0);
        check("one_rr", 64'(dut.rr_ptr_q), 3);

        clean();
        for (int s = 0; s < NS; s++) begin
            ex[s]        = newent(s);
            src_entry[s] = ex[s];
        end
        src_valid = 4'hF;
        tick();
        src_valid = '0;
        tick();
        check("cont1_vld", 64'(cdb_valid), 64'b11);
        check("cont1_sid", 64'(cdb_src_id), 64'({2'd1, 2'd0}));
        check("cont1_ent0", 64'(cdb_entry[0]), 64'(ex[0]));
        check("cont1_ent1", 64'(cdb_entry[1]), 64'(ex[1]));
        tick();
        check("cont2_vld", 64'(cdb_valid), 64'b11);
        check("cont2_sid", 64'(cdb_src_id), 64'({2'd3, 2'd2}));
        check("cont2_ent1", 64'(cdb_entry[1]), 64'(ex[3]));
        check("cont2_rr", 64'(dut.rr_ptr_q), 0);
        tick();
        check("cont_idle", 64'(cdb_valid), 0);

        // src 0 joins a flood late and is passed over until full
        clean();
        na      = 0;
        base    = nbc[0];
        rdy_tbl = 6'b101111;
        for (int k = 0; k < 6; k++) begin
            for (int s = 1; s < NS; s++) begin
                if (!src_valid[s] || acc[s]) begin
                    src_valid[s] = 1'b1;
                    src_entry[s] = newent(s);
                end
            end
            if (k >= 2 && (!src_valid[0] || acc[0])) begin
                src_valid[0] = (na < 3);
                src_entry[0] = newent(0);
                na++;
            end
            check("full_rdy0", 64'(src_ready[0]), 64'(rdy_tbl[k]));
            tick();
        end
        for (int c = 0; c < 20; c++) begin
            for (int s = 0; s < NS; s++) if (acc[s]) src_valid[s] = 1'b0;
            tick();
        end
        check("full_n0", 64'(nbc[0] - base), 3);
        for (int s = 0; s < NS; s++) check("full_drain", 64'(sbq[s].size()), 0);

        clean();
        src_valid = 4'hF;
        for (int s = 0; s < NS; s++) src_entry[s] = newent(s);
        tick();
        src_valid = 4'b0111;
        for (int s = 0; s < 3; s++) src_entry[s] = newent(s);
        tick();
        flush        = 1'b1;
        src_valid    = 4'b0010;
        src_entry[1] = newent(1);
        tick();
        flush     = 1'b0;
        src_valid = '0;
        check("fl_t1_vld", 64'(cdb_valid), 0);
        check("fl_rr", 64'(dut.rr_ptr_q), 0);
        check("fl_ready", 64'(src_ready), 64'hF);
        base = nbc[0] + nbc[1] + nbc[2] + nbc[3];
        tick();
        check("fl_t2_vld", 64'(cdb_valid), 0);
        repeat (6) tick();
        check("fl_quiet", 64'(nbc[0] + nbc[1] + nbc[2] + nbc[3] - base), 0);

        clean();
        for (int c = 0; c < 10000; c++) begin
            for (int s = 0; s < NS; s++) begin
                if (!src_valid[s] || acc[s]) begin
                    src_valid[s] = ($urandom_range(0, 99) < 55);
                    src_entry[s] = newent(s);
                end
            end
            tick();
        end
        for (int c = 0; c < 30; c++) begin
            for (int s = 0; s < NS; s++) if (acc[s]) src_valid[s] = 1'b0;
            tick();
        end
        for (int s = 0; s < NS; s++) check("soak_drain", 64'(sbq[s].size()), 0);
        check("soak_idle", 64'(cdb_valid), 0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
